// File: rtl/ct_spsram_param_memshade_pkg.sv
// +----------------------------------------------------------------------+
// | ct_spsram_pkg : shared types and helpers for the shadowed SP-SRAM     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package ct_spsram_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int unsigned MAX_DATA_WIDTH = 256;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Callers slice the low DATA_WIDTH bits out of this as a constant.
  function automatic logic [MAX_DATA_WIDTH-1:0] taint_fill(input logic flag);
    return flag ? {MAX_DATA_WIDTH{1'b1}} : {MAX_DATA_WIDTH{1'b0}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ct_spsram_param_memshade_if.sv
// +----------------------------------------------------------------------+
// | ct_spsram_param_memshade_if : SRAM access bus with taint companions   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

interface ct_spsram_param_memshade_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 59
);
  logic                  CEN;
  logic                  GWEN;
  logic [DATA_WIDTH-1:0] WEN;
  logic [ADDR_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;
  logic                  CEN_t0;
  logic                  GWEN_t0;
  logic [DATA_WIDTH-1:0] WEN_t0;
  logic [ADDR_WIDTH-1:0] A_t0;
  logic [DATA_WIDTH-1:0] D_t0;
  logic [DATA_WIDTH-1:0] Q_t0;
  logic                  INIT_DONE;

  modport master (
    output CEN, GWEN, WEN, A, D, CEN_t0, GWEN_t0, WEN_t0, A_t0, D_t0,
    input  Q, Q_t0, INIT_DONE
  );

  modport slave (
    input  CEN, GWEN, WEN, A, D, CEN_t0, GWEN_t0, WEN_t0, A_t0, D_t0,
    output Q, Q_t0, INIT_DONE
  );
endinterface

`default_nettype wire

// File: rtl/ct_spsram_param_memshade_init_ctrl.sv
// +----------------------------------------------------------------------+
// | ct_spsram_init_ctrl : post-reset zeroing sweep and access gating      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module ct_spsram_init_ctrl
  import ct_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int DEPTH         = 1 << ADDR_WIDTH,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen_i,
  output logic                  cen_o,
  output logic                  sweep_we_o,
  output logic [ADDR_WIDTH-1:0] sweep_addr_o,
  output logic                  init_done_o
);

  localparam int     CNT_W     = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam state_e RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             init_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DEPTH - 1)) begin
            state_q     <= ST_READY;
            cnt_q       <= '0;
            init_done_q <= 1'b1;
          end
        end
        ST_READY: begin
          init_done_q <= 1'b1;
        end
      endcase
    end
  end

  // User access is only let through once the sweep has finished.
  assign cen_o        = cen_i | rst | (state_q != ST_READY);
  assign sweep_we_o   = (state_q == ST_INIT) & ~rst;
  assign sweep_addr_o = ADDR_WIDTH'(cnt_q);
  assign init_done_o  = init_done_q;

endmodule

`default_nettype wire

// File: rtl/ct_spsram_param_memshade.sv
// +----------------------------------------------------------------------+
// | ct_spsram_param_memshade : parametrised SP-SRAM with taint shadow     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module ct_spsram_param_memshade
  import ct_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 59,
  parameter int DEPTH         = 1 << ADDR_WIDTH,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  ct_spsram_param_memshade_if.slave    bus
);

  localparam logic [MAX_DATA_WIDTH-1:0] TAINT_FULL = taint_fill(1'b1);
  localparam logic [DATA_WIDTH-1:0]     TAINT_ONES = TAINT_FULL[DATA_WIDTH-1:0];

  logic                  cen_gated;
  logic                  sweep_we;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic                  rd_en;
  logic                  wr_en;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] ctl_mask;
  logic [DATA_WIDTH-1:0] wr_taint;
  logic [DATA_WIDTH-1:0] rd_force;

  logic [DATA_WIDTH-1:0] mem_q    [DEPTH];
  logic [DATA_WIDTH-1:0] mem_t0_q [DEPTH];
  logic [DATA_WIDTH-1:0] q_q;
  logic [DATA_WIDTH-1:0] q_t0_q;
  logic                  sticky_q;

  ct_spsram_init_ctrl #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DEPTH         (DEPTH),
    .INIT_ON_RESET (INIT_ON_RESET)
  ) u_init_ctrl (
    .clk          (CLK),
    .rst          (RST),
    .cen_i        (bus.CEN),
    .cen_o        (cen_gated),
    .sweep_we_o   (sweep_we),
    .sweep_addr_o (sweep_addr),
    .init_done_o  (bus.INIT_DONE)
  );

  assign rd_en    = ~cen_gated & bus.GWEN;
  assign wr_en    = ~cen_gated & ~bus.GWEN;
  assign in_range = (32'(bus.A) < 32'(DEPTH));
  assign ctl_mask = (bus.CEN_t0 | bus.GWEN_t0) ? TAINT_ONES : '0;
  assign wr_taint = bus.D_t0 | bus.WEN_t0 | ctl_mask;
  assign rd_force = (|bus.A_t0 | bus.CEN_t0 | bus.GWEN_t0 | sticky_q) ? TAINT_ONES : '0;

  // Masked-off bits keep their data but still accumulate control taint.
  always_ff @(posedge CLK) begin
    if (sweep_we) begin
      mem_q[sweep_addr]    <= '0;
      mem_t0_q[sweep_addr] <= '0;
    end else if (wr_en && in_range) begin
      mem_q[bus.A]    <= (mem_q[bus.A] & bus.WEN) | (bus.D & ~bus.WEN);
      mem_t0_q[bus.A] <= (~bus.WEN & wr_taint)
                       | (bus.WEN & (mem_t0_q[bus.A] | bus.WEN_t0 | ctl_mask));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q      <= '0;
      q_t0_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      if (wr_en && |bus.A_t0) begin
        sticky_q <= 1'b1;
      end
      if (rd_en) begin
        if (in_range) begin
          q_q    <= mem_q[bus.A];
          q_t0_q <= mem_t0_q[bus.A] | rd_force;
        end else begin
          q_q    <= '0;
          q_t0_q <= TAINT_ONES;
        end
      end
    end
  end

  assign bus.Q    = q_q;
  assign bus.Q_t0 = q_t0_q;

endmodule

`default_nettype wire

// File: tb/tb_ct_spsram_param_memshade.sv
// +----------------------------------------------------------------------+
// | tb_ct_spsram_param_memshade : scoreboard bench, two parametrisations  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ct_spsram_param_memshade;

  localparam int AW0 = 10, DW0 = 59, DEP0 = 1024;
  localparam int AW1 = 4,  DW1 = 8,  DEP1 = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;

  ct_spsram_param_memshade_if #(.ADDR_WIDTH(AW0), .DATA_WIDTH(DW0)) if0 ();
  ct_spsram_param_memshade_if #(.ADDR_WIDTH(AW1), .DATA_WIDTH(DW1)) if1 ();

  ct_spsram_param_memshade #(.ADDR_WIDTH(AW0), .DATA_WIDTH(DW0), .DEPTH(DEP0), .INIT_ON_RESET(1))
    dut0 (.CLK(clk), .RST(rst0), .bus(if0));
  ct_spsram_param_memshade #(.ADDR_WIDTH(AW1), .DATA_WIDTH(DW1), .DEPTH(DEP1), .INIT_ON_RESET(1))
    dut1 (.CLK(clk), .RST(rst1), .bus(if1));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] q;
    logic [63:0] qt;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  bit   rd_issue0, rd_issue1, rd_seen0, rd_seen1;

  // Reference model: plain arrays, one bank per DUT, widths up to 64 bits.
  logic [63:0] m_data [2][1024];
  logic [63:0] m_t0   [2][1024];
  bit          m_sticky [2];
  bit          m_ready  [2];
  logic [63:0] m_lastq  [2];
  logic [63:0] m_lastqt [2];
  int          dw    [2] = '{DW0, DW1};
  int          depth [2] = '{DEP0, DEP1};

  function automatic logic [63:0] wmask(int id);
    return (64'd1 << dw[id]) - 64'd1;
  endfunction

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_write(int id, logic [63:0] a, logic [63:0] d, logic [63:0] wen,
                                      bit ct, bit gt, logic [63:0] at, logic [63:0] dt,
                                      logic [63:0] wt);
    if (!m_ready[id]) return;
    if (at != 64'd0) m_sticky[id] = 1'b1;
    if (a >= 64'(depth[id])) return;
    for (int i = 0; i < dw[id]; i++) begin
      if (!wen[i]) begin
        m_data[id][int'(a)][i] = d[i];
        m_t0[id][int'(a)][i]   = dt[i] | wt[i] | gt | ct;
      end else if (wt[i] || gt || ct) begin
        m_t0[id][int'(a)][i] = 1'b1;
      end
    end
  endfunction

  function automatic exp_t model_read(int id, logic [63:0] a, bit ct, bit gt, logic [63:0] at);
    exp_t e;
    if (!m_ready[id]) begin
      e.q  = m_lastq[id];
      e.qt = m_lastqt[id];
      return e;
    end
    if (a >= 64'(depth[id])) begin
      e.q  = 64'd0;
      e.qt = wmask(id);
    end else begin
      e.q  = m_data[id][int'(a)];
      e.qt = ((at != 64'd0) || ct || gt || m_sticky[id]) ? wmask(id) : m_t0[id][int'(a)];
    end
    m_lastq[id]  = e.q;
    m_lastqt[id] = e.qt;
    return e;
  endfunction

  task automatic set_idle();
    if0.CEN = 1'b1; if0.GWEN = 1'b1; if0.WEN = '1; if0.A = '0; if0.D = '0;
    if0.CEN_t0 = 1'b0; if0.GWEN_t0 = 1'b0; if0.WEN_t0 = '0; if0.A_t0 = '0; if0.D_t0 = '0;
    if1.CEN = 1'b1; if1.GWEN = 1'b1; if1.WEN = '1; if1.A = '0; if1.D = '0;
    if1.CEN_t0 = 1'b0; if1.GWEN_t0 = 1'b0; if1.WEN_t0 = '0; if1.A_t0 = '0; if1.D_t0 = '0;
    rd_issue0 = 1'b0;
    rd_issue1 = 1'b0;
  endtask

  task automatic drive(int id, bit cen, bit gwen, logic [63:0] a, logic [63:0] d,
                       logic [63:0] wen, bit ct, bit gt, logic [63:0] at,
                       logic [63:0] dt, logic [63:0] wt);
    exp_t e;
    @(negedge clk);
    set_idle();
    if (id == 0) begin
      if0.CEN = cen; if0.GWEN = gwen; if0.A = a[AW0-1:0]; if0.D = d[DW0-1:0];
      if0.WEN = wen[DW0-1:0]; if0.CEN_t0 = ct; if0.GWEN_t0 = gt; if0.A_t0 = at[AW0-1:0];
      if0.D_t0 = dt[DW0-1:0]; if0.WEN_t0 = wt[DW0-1:0];
    end else begin
      if1.CEN = cen; if1.GWEN = gwen; if1.A = a[AW1-1:0]; if1.D = d[DW1-1:0];
      if1.WEN = wen[DW1-1:0]; if1.CEN_t0 = ct; if1.GWEN_t0 = gt; if1.A_t0 = at[AW1-1:0];
      if1.D_t0 = dt[DW1-1:0]; if1.WEN_t0 = wt[DW1-1:0];
    end
    if (!cen && !gwen) begin
      model_write(id, a, d, wen, ct, gt, at, dt, wt);
    end else if (!cen && gwen) begin
      e = model_read(id, a, ct, gt, at);
      if (id == 0) begin sb0.push_back(e); rd_issue0 = 1'b1; end
      else         begin sb1.push_back(e); rd_issue1 = 1'b1; end
    end
  endtask

  task automatic rd(int id, logic [63:0] a, logic [63:0] at = 64'd0);
    drive(id, 1'b0, 1'b1, a, 64'd0, '1, 1'b0, 1'b0, at, 64'd0, 64'd0);
  endtask

  task automatic wr(int id, logic [63:0] a, logic [63:0] d, logic [63:0] wen,
                    logic [63:0] dt = 64'd0, logic [63:0] at = 64'd0);
    drive(id, 1'b0, 1'b0, a, d, wen, 1'b0, 1'b0, at, dt, 64'd0);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      set_idle();
    end
  endtask

  function automatic logic init_done(int id);
    return (id == 0) ? if0.INIT_DONE : if1.INIT_DONE;
  endfunction

  task automatic do_reset(int id, int cycles, bit chk);
    @(negedge clk);
    set_idle();
    if (id == 0) rst0 = 1'b1; else rst1 = 1'b1;
    idle(cycles);
    if (chk) begin
      check("rst_init_done", 64'(init_done(id)), 64'd0);
      check("rst_q",  (id == 0) ? 64'(if0.Q)    : 64'(if1.Q),    64'd0);
      check("rst_qt", (id == 0) ? 64'(if0.Q_t0) : 64'(if1.Q_t0), 64'd0);
    end
    if (id == 0) rst0 = 1'b0; else rst1 = 1'b0;
    m_sticky[id] = 1'b0;
    m_ready[id]  = 1'b0;
    m_lastq[id]  = 64'd0;
    m_lastqt[id] = 64'd0;
  endtask

  task automatic wait_init(int id, int expect_n);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      set_idle();
      n++;
      done = init_done(id);
    end
    check("init_latency", 64'(n), 64'(expect_n));
    for (int i = 0; i < depth[id]; i++) begin
      m_data[id][i] = 64'd0;
      m_t0[id][i]   = 64'd0;
    end
    m_ready[id] = 1'b1;
  endtask

  task automatic rand_phase(int id, int n);
    logic [63:0] a, d, wen, dt, wt, at;
    bit ct, gt;
    int sel;
    for (int k = 0; k < n; k++) begin
      sel = $urandom_range(0, 3);
      if (id == 0)
        a = $urandom_range(0, 1) ? 64'($urandom_range(0, 15)) : 64'($urandom_range(1016, 1023));
      else
        a = 64'($urandom_range(0, 15));
      d   = {$urandom, $urandom};
      wen = {$urandom, $urandom};
      dt  = ($urandom_range(0, 3) == 0) ? (64'd1 << $urandom_range(0, 7)) : 64'd0;
      wt  = ($urandom_range(0, 3) == 0) ? (64'd1 << $urandom_range(0, 7)) : 64'd0;
      ct  = ($urandom_range(0, 7) == 0);
      gt  = ($urandom_range(0, 7) == 0);
      at  = ($urandom_range(0, 7) == 0) ? 64'd1 : 64'd0;
      case (sel)
        0:       drive(id, 1'b1, 1'($urandom_range(0, 1)), a, d, wen, ct, gt, at, dt, wt);
        1:       drive(id, 1'b0, 1'b0, a, d, wen, ct, gt, 64'd0, dt, wt);
        default: drive(id, 1'b0, 1'b1, a, d, wen, ct, gt, at, dt, wt);
      endcase
    end
  endtask

  // Monitor: a read issued before the last rising edge has its result on Q now.
  always @(posedge clk) begin
    rd_seen0 <= rd_issue0;
    rd_seen1 <= rd_issue1;
  end

  always @(negedge clk) begin
    exp_t e0, e1;
    if (rd_seen0) begin
      if (sb0.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb0_underflow actual=read_seen expected=queued_entry");
      end else begin
        e0 = sb0.pop_front();
        check("dut0_q",  64'(if0.Q),    e0.q);
        check("dut0_qt", 64'(if0.Q_t0), e0.qt);
      end
    end
    if (rd_seen1) begin
      if (sb1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb1_underflow actual=read_seen expected=queued_entry");
      end else begin
        e1 = sb1.pop_front();
        check("dut1_q",  64'(if1.Q),    e1.q);
        check("dut1_qt", 64'(if1.Q_t0), e1.qt);
      end
    end
  end

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    set_idle();

    // Large instance: sweep, clean reads, masked write, data taint.
    do_reset(0, 3, 1'b1);
    wait_init(0, 1024);
    rd(0, 0); rd(0, 511); rd(0, 1023);
    wr(0, 5, '1, 64'h07FF_FFFF_0000_0000);
    rd(0, 5);
    wr(0, 7, 64'h1234, 64'd0, 64'h8);
    rd(0, 7);
    rd(0, 7, 64'd1);
    rand_phase(0, 300);

    // Reset in the middle of the sweep; a write issued during INIT is dropped.
    do_reset(0, 2, 1'b0);
    idle(300);
    check("midsweep_init_done", 64'(if0.INIT_DONE), 64'd0);
    wr(0, 20, '1, 64'd0);
    rd(0, 20);
    do_reset(0, 2, 1'b0);
    check("rst_drop_init_done", 64'(if0.INIT_DONE), 64'd0);
    wait_init(0, 1024);
    rd(0, 20);

    // Sticky address taint survives until reset.
    wr(0, 9, 64'h55, 64'd0, 64'd0, 64'd1);
    rd(0, 3); rd(0, 100); rd(0, 9);
    do_reset(0, 2, 1'b0);
    wait_init(0, 1024);
    rd(0, 9);

    // Small instance: out-of-range handling and random traffic.
    do_reset(1, 3, 1'b1);
    wait_init(1, 12);
    wr(1, 13, 64'hFF, 64'd0);
    rd(1, 13);
    wr(1, 11, 64'hA5, 64'd0);
    rd(1, 11);
    rand_phase(1, 300);

    idle(4);
    check("sb0_drained", 64'(sb0.size()), 64'd0);
    check("sb1_drained", 64'(sb1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ct_spsram_param_memshade.md
Name: ct_spsram_param_memshade

Overview:
- Parametrised single-port SRAM behavioural model for FPGA and simulation builds, with real taint propagation through a shadow array.
- Replaces the fixed-size spsram wrappers whose taint output is tied to zero.
- Adds a post-reset zeroing sweep, so the data and taint arrays start in a known state.
- Sits wherever the core instantiates a spsram: caches, TLBs, predictors.

Parameters:
- ADDR_WIDTH, 10, address bits.
- DATA_WIDTH, 59, data and write-mask width.
- DEPTH, 1<<ADDR_WIDTH, number of entries. Must be ≤ 2^ADDR_WIDTH.
- INIT_ON_RESET, 1. 1 = zero both arrays after reset; 0 = skip the sweep.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- CEN  in  1  chip enable, active low.
- GWEN  in  1  global write enable, active low.
- WEN  in  DATA_WIDTH  per-bit write enable, active low.
- A  in  ADDR_WIDTH  address.
- D  in  DATA_WIDTH  write data.
- Q  out  DATA_WIDTH  read data.
- CEN_t0, GWEN_t0, WEN_t0, A_t0, D_t0  in  same widths as their data ports  taint of the matching input.
- Q_t0  out  DATA_WIDTH  taint of Q.
- INIT_DONE  out  1  high once the array is usable.

Behaviour:
- Clocking: one clock, CLK. RST is synchronous, active-high, and sampled on the CLK rising edge.
- Reset values: Q=0, Q_t0=0, INIT_DONE=0, sticky address-taint flag=0, FSM=INIT (or READY when INIT_ON_RESET=0).
- FSM states:
  - INIT: sweep counter starts at 0. Each cycle it writes mem[cnt]=0 and mem_t0[cnt]=0, then increments. At cnt==DEPTH-1 it moves to READY.
  - READY: normal operation. INIT_DONE=1 registered, first high the cycle after the last sweep write.
- Sweep timing:
  - The sweep takes exactly DEPTH cycles after RST deasserts.
  - With INIT_ON_RESET=0, INIT_DONE rises on the first edge after RST deasserts.
- Behaviour while in INIT:
  - CEN is forced inactive; user reads and writes are dropped.
  - Q and Q_t0 stay 0.
- RST asserted mid-sweep: the sweep restarts from 0 and INIT_DONE drops.
- Read: CEN=0, GWEN=1, A<DEPTH.
  - 1-cycle latency: Q = mem[A] and Q_t0 = mem_t0[A] on the next edge.
- Q when not reading: holds its last value on idle (CEN=1) and on write cycles.
- Write: CEN=0, GWEN=0, A<DEPTH.
  - Bit i of mem[A] is updated only when WEN[i]=0; unmasked bits are unchanged.
- Out-of-range A (≥DEPTH): writes are ignored; reads return Q=0, Q_t0 all-ones.
- Write taint, per bit i written or gated:
  - mem_t0[A][i] = D_t0[i] | WEN_t0[i] | GWEN_t0 | CEN_t0.
  - A bit whose WEN[i]=1 but WEN_t0[i]=1 keeps its data and has its taint ORed with 1.
  - If CEN_t0 or GWEN_t0 is set, every bit's taint is ORed in the same way, whether or not it was written.
- Tainted write address: on any write with |A_t0, the sticky flag sets. While the flag is set, every read returns Q_t0 all-ones. The flag clears only on RST.
- Read taint: Q_t0 = mem_t0[A] | {DATA_WIDTH{|A_t0 | CEN_t0 | GWEN_t0 | sticky}}.
- Taint of control inputs on idle cycles: ignored.
- The sweep does not clear the sticky flag; only RST does.

Decomposition:
- Package ct_spsram_pkg holds:
  - the state enum {ST_INIT, ST_READY};
  - localparam function clog2;
  - a helper for the all-ones taint mask.
- Sub-module ct_spsram_init_ctrl holds the FSM, the sweep counter, INIT_DONE, and the forced-CEN gating.
- The top level holds the data array, the taint array, the sticky flag and the output registers.

Test Plan:
- Reset, INIT_ON_RESET=1, DEPTH=1024: INIT_DONE rises exactly 1024 cycles after RST drops. Reads of addresses 0, 511 and 1023 return Q=0, Q_t0=0.
- Masked write, taints clear: write A=5, D=all-ones, WEN=0x7FF_FFFF_0000_0000 (bits 31:0 enabled). Read A=5 → Q=0x000_0000_FFFF_FFFF, Q_t0=0.
- Data taint: write A=7 with D_t0=bit3. Read A=7 with clean controls → Q_t0=0x8. Then read with A_t0=1 → Q_t0 all-ones.
- Sticky address taint: write A=9 with A_t0=0x001. Reads of any address then return Q_t0 all-ones until RST; after reset plus sweep, Q_t0=0.
- RST pulse at sweep cycle 300: INIT_DONE stays 0 and the count restarts; INIT_DONE rises 1024 cycles after the second RST drops. A write issued during INIT is dropped, and the address reads 0.
- Parametrisation: ADDR_WIDTH=4, DEPTH=12, DATA_WIDTH=8. Write A=13 is ignored. Read A=13 → Q=0, Q_t0=0xFF. Read A=11 returns the last value written there.
